spi_reg_bank: RTL and testbench
===============================

// Module: spi_reg_bank
// PURPOSE
//  SPI peripheral (mode 0, MSB first) with a parametrised register bank and full read/write access.
//  Successor to the write-only control-register SPI slave: adds readback on cipo, frame abort on nCS,
//  and generic address/data widths and register count. Sits between the chip pads and the PWM/output logic.
//  All SPI inputs are asynchronous to clk and are oversampled (clk >= 8x sclk).
// PARAMETERS
//  ADDR_W       7   address field width in bits
//  DATA_W       8   data field width, and the width of each register
//  NUM_REGS     5   number of implemented registers, at addresses 0..NUM_REGS-1
//  SYNC_STAGES  2   synchroniser depth on ncs/sclk/copi (>=2)
// PORTS
//  clk        in   1                  system clock
//  rst_n      in   1                  synchronous, active-low reset
//  ncs        in   1                  chip select, active low, async
//  sclk       in   1                  SPI clock, async
//  copi       in   1                  controller-out data, async
//  cipo       out  1                  peripheral-out data (0 when not driving)
//  cipo_oe    out  1                  high while the read data phase is driving cipo
//  regs_flat  out  NUM_REGS*DATA_W    register contents; reg i is at [i*DATA_W +: DATA_W]
//  wr_strobe  out  1                  one-clk pulse when a register is written
//  wr_addr    out  ADDR_W             address of the last write; valid while wr_strobe is high
// BEHAVIOUR
//  Frame = 1+ADDR_W+DATA_W bits: bit0 RW (1=write, 0=read), then address, then data; all MSB first.
//  Sampling: copi is sampled on each detected sclk rising edge; cipo updates on each detected sclk falling edge.
//  Edge detection: a sync'd edge is taken from the last two synchroniser stages, giving 1 clk of detection latency after sync.
//  Reset: every register = 0, cipo=0, cipo_oe=0, wr_strobe=0, wr_addr=0, FSM=IDLE, and all shift/count regs cleared.
//  FSM states:
//    IDLE: waits for the sync'd ncs falling edge, then clears the bit counter -> ADDR.
//    ADDR: shifts RW and the address bits. After the last address bit:
//          - if the frame is a read, loads shift_out = reg[addr] (0 if addr >= NUM_REGS),
//            drives cipo = shift_out MSB and sets cipo_oe=1;
//          - in either case -> DATA.
//    DATA: write = shifts copi into the data field; read = shifts shift_out left on each falling edge.
//          After the DATA_W-th rising edge -> DONE.
//    DONE: one clk. For a write with addr < NUM_REGS: reg[addr] <= data, wr_strobe=1, wr_addr=addr.
//          Then -> WAIT_CS.
//    WAIT_CS: ignores all sclk edges until ncs is sync'd high -> IDLE; cipo_oe=0, cipo=0.
//  Boundary conditions:
//   - ncs sync'd high in ADDR or DATA: abort. No write, no strobe, cipo_oe=0, -> IDLE.
//   - ncs rise in the same clk as the final rising edge: the edge completes the frame; the commit happens.
//   - Extra sclk pulses after a full frame are ignored, since the FSM is in WAIT_CS.
//   - A write to addr >= NUM_REGS is dropped with no strobe. A read of addr >= NUM_REGS returns all zeros.
//   - A read never changes any register.
//   - Back-to-back frames require ncs to go high between them.
//   - rst_n low at any point, including mid-frame: immediate reset values; the partial frame is discarded.
//   - sclk edges while in IDLE (ncs high) have no effect.
// STRUCTURE
//  spi_pkg: state enum {IDLE, ADDR, DATA, DONE, WAIT_CS}, the function frame_len(ADDR_W, DATA_W),
//           and the RW bit encodings.
//  Sub-module spi_sync_edge: SYNC_STAGES-deep synchroniser with rise/fall pulse outputs.
//           Instantiated for ncs, sclk and copi (level output only for copi).
//  Top level holds the FSM, the bit counter ($clog2 of frame length), the shift registers and the register array.
// TESTING
//  1. Write: RW=1, addr=4, data=0xA5 -> reg4=0xA5; wr_strobe exactly 1 clk wide; wr_addr=4; other registers stay 0.
//  2. Readback: write 0x3C to addr 2, then read addr 2 -> cipo shows 0,0,1,1,1,1,0,0 on 8 rising edges;
//     cipo_oe is high only during the data phase.
//  3. Abort: start a write to addr 1 with data 0xFF and raise ncs after 10 bits -> reg1 stays 0, no strobe;
//     the next full frame works normally.
//  4. Out of range: write 0x77 to addr 0x50 -> no register changes, no strobe; a read of 0x50 returns 0x00.
//  5. Overrun and abort: 20 sclk pulses in one write frame to addr 0 -> only the first 16 bits count;
//     reg0 = the data in bits 8..15.
//  6. Reset mid-frame: assert rst_n low after 12 bits of a write -> all registers 0; after release,
//     a fresh write to addr 3 of 0x81 succeeds.

Source files
------------

// File: rtl/spi_reg_bank_pkg.sv
// Shared types and frame helpers for the SPI register bank.
package spi_reg_bank_pkg;
   typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, WAIT_CS} spi_state_e;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   function automatic int frame_len(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction
endpackage

// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between the pads (controller side) and the register bank.
interface spi_reg_bank_if;
   logic ncs;
   logic sclk;
   logic copi;
   logic cipo;
   logic cipo_oe;

   modport master (output ncs, sclk, copi, input cipo, cipo_oe);
   modport slave  (input ncs, sclk, copi, output cipo, cipo_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an async input, with registered-history edge pulses.
module spi_sync_edge #(
   parameter int STAGES  = 2,
   parameter bit RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sync;
   logic              prev;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync <= {STAGES{RST_VAL}};
         prev <= RST_VAL;
      end else begin
         sync <= {sync[STAGES-2:0], d};
         prev <= sync[STAGES-1];
      end
   end

   assign q    = sync[STAGES-1];
   assign rise = q & ~prev;
   assign fall = ~q & prev;
endmodule

// File: rtl/spi_reg_bank.sv
// Mode-0 SPI peripheral exposing a small read/write register bank.
module spi_reg_bank
   import spi_reg_bank_pkg::*;
#(
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 8,
   parameter int NUM_REGS    = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   spi_reg_bank_if.slave              spi,
   output logic [NUM_REGS*DATA_W-1:0] regs_flat,
   output logic                       wr_strobe,
   output logic [ADDR_W-1:0]          wr_addr
);
   localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
   localparam int CNT_W     = $clog2(FRAME_LEN);
   localparam logic [CNT_W-1:0] LAST_ADDR_BIT  = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0] FIRST_DATA_BIT = CNT_W'(ADDR_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT       = CNT_W'(FRAME_LEN - 1);

   logic ncs_q, ncs_fall, ncs_rise_unused;
   logic sclk_q_unused, sclk_rise, sclk_fall;
   logic copi_q, copi_rise_unused, copi_fall_unused;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
      .clk(clk), .rst_n(rst_n), .d(spi.ncs),
      .q(ncs_q), .rise(ncs_rise_unused), .fall(ncs_fall));
   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .d(spi.sclk),
      .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall));
   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_copi (
      .clk(clk), .rst_n(rst_n), .d(spi.copi),
      .q(copi_q), .rise(copi_rise_unused), .fall(copi_fall_unused));

   logic [NUM_REGS-1:0][DATA_W-1:0] regs;
   spi_state_e                      state;
   logic [CNT_W-1:0]                cnt;
   logic [ADDR_W:0]                 hdr, hdr_nxt;
   logic [DATA_W-1:0]               data_sr, shift_out, rd_data;
   logic                            rw;
   logic [ADDR_W-1:0]               addr;
   logic                            addr_hit;

   assign regs_flat = regs;
   assign hdr_nxt   = {hdr[ADDR_W-1:0], copi_q};
   assign addr_hit  = (int'(addr) < NUM_REGS);

   // Read mux is keyed on the address as it completes, so cipo can be loaded on that same edge.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (hdr_nxt[ADDR_W-1:0] == ADDR_W'(i)) rd_data = regs[i];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         hdr       <= '0;
         data_sr   <= '0;
         shift_out <= '0;
         rw        <= RW_READ;
         addr      <= '0;
         regs      <= '0;
         spi.cipo    <= 1'b0;
         spi.cipo_oe <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
      end else begin
         wr_strobe <= 1'b0;
         case (state)
            IDLE: if (ncs_fall) begin
               state   <= ADDR;
               cnt     <= '0;
               hdr     <= '0;
               data_sr <= '0;
            end
            ADDR: if (ncs_q) begin
               state <= IDLE;
            end else if (sclk_rise) begin
               hdr <= hdr_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == LAST_ADDR_BIT) begin
                  state <= DATA;
                  rw    <= hdr_nxt[ADDR_W];
                  addr  <= hdr_nxt[ADDR_W-1:0];
                  if (hdr_nxt[ADDR_W] == RW_READ) begin
                     shift_out   <= rd_data;
                     spi.cipo    <= rd_data[DATA_W-1];
                     spi.cipo_oe <= 1'b1;
                  end
               end
            end
            DATA: if (sclk_rise && cnt == LAST_BIT) begin
               // Final edge wins over a simultaneous ncs release.
               data_sr     <= {data_sr[DATA_W-2:0], copi_q};
               state       <= DONE;
               spi.cipo    <= 1'b0;
               spi.cipo_oe <= 1'b0;
            end else if (ncs_q) begin
               state       <= IDLE;
               spi.cipo    <= 1'b0;
               spi.cipo_oe <= 1'b0;
            end else if (sclk_rise) begin
               data_sr <= {data_sr[DATA_W-2:0], copi_q};
               cnt     <= cnt + 1'b1;
            end else if (sclk_fall && rw == RW_READ && cnt != FIRST_DATA_BIT) begin
               // The fall right after the address keeps the MSB already on cipo.
               shift_out <= shift_out << 1;
               spi.cipo  <= shift_out[DATA_W-2];
            end
            DONE: begin
               if (rw == RW_WRITE && addr_hit) begin
                  for (int i = 0; i < NUM_REGS; i++)
                     if (addr == ADDR_W'(i)) regs[i] <= data_sr;
                  wr_strobe <= 1'b1;
                  wr_addr   <= addr;
               end
               state <= WAIT_CS;
            end
            WAIT_CS: if (ncs_q) begin
               state       <= IDLE;
               spi.cipo    <= 1'b0;
               spi.cipo_oe <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: write, readback, abort, range, overrun and reset cases.
module tb_spi_reg_bank;
   localparam int HALF = 80;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [39:0] regs_flat;
   logic        wr_strobe;
   logic [6:0]  wr_addr;

   int n_chk = 0;
   int n_pass = 0;
   int strobe_total = 0;
   int last_wr_addr = -1;

   spi_reg_bank_if spi ();

   spi_reg_bank #(.ADDR_W(7), .DATA_W(8), .NUM_REGS(5), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .spi(spi),
      .regs_flat(regs_flat), .wr_strobe(wr_strobe), .wr_addr(wr_addr));

   always #5 clk = ~clk;

   always @(negedge clk) if (wr_strobe) begin
      strobe_total++;
      last_wr_addr = int'(wr_addr);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic spi_frame(input bit rw, input logic [6:0] a, input logic [7:0] d,
                            input int nbits, input bit hold_cs,
                            output logic [7:0] rdata, output bit oe_hdr, output bit oe_data);
      logic [19:0] bits;
      bits    = {rw, a, d, 4'hF};
      rdata   = '0;
      oe_hdr  = 1'b0;
      oe_data = 1'b1;
      spi.ncs = 1'b0;
      #HALF;
      for (int i = 0; i < nbits; i++) begin
         spi.copi = bits[19-i];
         #HALF;
         if (i < 8) oe_hdr = oe_hdr | spi.cipo_oe;
         else if (i < 16) begin
            rdata   = {rdata[6:0], spi.cipo};
            oe_data = oe_data & spi.cipo_oe;
         end
         spi.sclk = 1'b1;
         #HALF;
         spi.sclk = 1'b0;
      end
      #HALF;
      spi.copi = 1'b0;
      if (!hold_cs) begin
         spi.ncs = 1'b1;
         #(4*HALF);
      end
   endtask

   initial begin
      logic [7:0] rd;
      bit         oh, od;
      int         s0;
      rst_n    = 1'b0;
      spi.ncs  = 1'b1;
      spi.sclk = 1'b0;
      spi.copi = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_regs",    64'(regs_flat), 64'h0);
      chk("rst_cipo",    64'(spi.cipo), 64'h0);
      chk("rst_cipo_oe", 64'(spi.cipo_oe), 64'h0);
      chk("rst_strobe",  64'(wr_strobe), 64'h0);
      chk("rst_wr_addr", 64'(wr_addr), 64'h0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Plain write
      s0 = strobe_total;
      spi_frame(1'b1, 7'd4, 8'hA5, 16, 1'b0, rd, oh, od);
      chk("wr4_regs",   64'(regs_flat), 64'hA5_00_00_00_00);
      chk("wr4_strobe", 64'(strobe_total - s0), 64'd1);
      chk("wr4_addr",   64'(last_wr_addr), 64'd4);
      chk("wr4_addr_hold", 64'(wr_addr), 64'd4);

      // Write then read back
      s0 = strobe_total;
      spi_frame(1'b1, 7'd2, 8'h3C, 16, 1'b0, rd, oh, od);
      chk("wr2_strobe", 64'(strobe_total - s0), 64'd1);
      s0 = strobe_total;
      spi_frame(1'b0, 7'd2, 8'h00, 16, 1'b0, rd, oh, od);
      chk("rd2_data",    64'(rd), 64'h3C);
      chk("rd2_oe_hdr",  64'(oh), 64'd0);
      chk("rd2_oe_data", 64'(od), 64'd1);
      chk("rd2_oe_after", 64'(spi.cipo_oe), 64'd0);
      chk("rd2_cipo_after", 64'(spi.cipo), 64'd0);
      chk("rd2_no_strobe", 64'(strobe_total - s0), 64'd0);
      chk("rd2_regs", 64'(regs_flat), 64'hA5_00_3C_00_00);

      // Abort after 10 bits, then a normal frame
      s0 = strobe_total;
      spi_frame(1'b1, 7'd1, 8'hFF, 10, 1'b0, rd, oh, od);
      chk("abort_strobe", 64'(strobe_total - s0), 64'd0);
      chk("abort_regs",   64'(regs_flat), 64'hA5_00_3C_00_00);
      spi_frame(1'b1, 7'd1, 8'h5A, 16, 1'b0, rd, oh, od);
      chk("post_abort_regs",   64'(regs_flat), 64'hA5_00_3C_5A_00);
      chk("post_abort_strobe", 64'(strobe_total - s0), 64'd1);

      // Out-of-range address
      s0 = strobe_total;
      spi_frame(1'b1, 7'h50, 8'h77, 16, 1'b0, rd, oh, od);
      chk("oor_strobe", 64'(strobe_total - s0), 64'd0);
      chk("oor_regs",   64'(regs_flat), 64'hA5_00_3C_5A_00);
      spi_frame(1'b0, 7'h50, 8'h00, 16, 1'b0, rd, oh, od);
      chk("oor_rd_data", 64'(rd), 64'h00);
      chk("oor_rd_oe",   64'(od), 64'd1);

      // Overrun: 20 pulses, only the first 16 bits count
      s0 = strobe_total;
      spi_frame(1'b1, 7'd0, 8'hC3, 20, 1'b0, rd, oh, od);
      chk("ovr_regs",   64'(regs_flat), 64'hA5_00_3C_5A_C3);
      chk("ovr_strobe", 64'(strobe_total - s0), 64'd1);

      // Reset mid-frame, then a fresh write
      s0 = strobe_total;
      spi_frame(1'b1, 7'd3, 8'hEE, 12, 1'b1, rd, oh, od);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_regs",   64'(regs_flat), 64'h0);
      chk("midrst_oe",     64'(spi.cipo_oe), 64'h0);
      chk("midrst_strobe", 64'(strobe_total - s0), 64'd0);
      rst_n   = 1'b1;
      spi.ncs = 1'b1;
      #(4*HALF);
      spi_frame(1'b1, 7'd3, 8'h81, 16, 1'b0, rd, oh, od);
      chk("post_rst_regs", 64'(regs_flat), 64'h00_81_00_00_00);
      chk("post_rst_addr", 64'(wr_addr), 64'd3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
